// File: rtl/mem_port_master.sv
// Memory port master: streams words into or out of a single-port RAM.
// Optional running checksum enabled by MEM_PORT_MASTER_CHECKSUM_EN.
module mem_port_master #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              done
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_HOLD,
    S_DONE
  } state_e;

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [ADDR_W:0]     cnt_sat;
  logic [ADDR_W:0]     idx_inc;
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  assign cnt_sat     = (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
  assign idx_inc     = idx_q + ONE;
  assign mem_address = base_q + idx_q[ADDR_W-1:0];
  assign mem_in      = (state_q == S_WR) ? wr_data : '0;
  assign rd_data     = rd_data_q;
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
  assign checksum    = sum_q;
`endif

  // next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    idx_d     = idx_q;
    rd_data_d = rd_data_q;
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    mem_load  = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          base_d  = cmd_base;
          count_d = cnt_sat;
          idx_d   = '0;
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
          sum_d   = '0;
`endif
          if (cnt_sat == '0) state_d = S_DONE;
          else if (cmd_write) state_d = S_WR;
          else state_d = S_RD_REQ;
        end
      end
      S_WR: begin
        wr_ready = 1'b1;
        mem_load = wr_valid;
        if (wr_valid) begin
          idx_d = idx_inc;
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
          sum_d = sum_q + wr_data;
`endif
          if (idx_inc == count_q) state_d = S_DONE;
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rd_data_d = mem_out;
        state_d   = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          idx_d = idx_inc;
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
          sum_d = sum_q + rd_data_q;
`endif
          if (idx_inc == count_q) state_d = S_DONE;
          else state_d = S_RD_REQ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a reset cycle must never write memory or accept write data
    if (!rst_n) begin
      mem_load = 1'b0;
      wr_ready = 1'b0;
    end
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      rd_data_q <= '0;
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      rd_data_q <= rd_data_d;
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: RAM model plus address/word reference model.
// Directed and random write/read commands, wrap, saturation, reset abort.
module tb_mem_port_master;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in;
  logic          mem_load;
  logic [DW-1:0] mem_out = '0;
  logic          busy;
  logic          done;
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_ref [DEPTH];
  logic [DW-1:0] wq [$];
  int n_chk = 0;
  int n_fail = 0;
  int n_writes = 0;
  int n_done = 0;
  int w0, d0;
  logic [AW-1:0] rb;

  mem_port_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_base(cmd_base),
    .cmd_count(cmd_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data),
    .mem_address(mem_address), .mem_in(mem_in),
    .mem_load(mem_load), .mem_out(mem_out),
    .busy(busy), .done(done)
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // synchronous RAM, read data one cycle after address
  always @(posedge clk) begin
    if (mem_load) begin
      mem[mem_address] <= mem_in;
      n_writes++;
    end
    mem_out <= mem[mem_address];
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  task automatic do_write(input logic [AW-1:0] base,
                          input logic [AW:0] cnt,
                          input int stall_pct);
    int n, i, cyc, wb, db;
    logic [AW-1:0] a;
    logic [DW-1:0] sum;
    n = sat(int'(cnt));
    wb = n_writes;
    db = n_done;
    sum = '0;
    i = 0;
    cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_base = base;
    cmd_count = cnt;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (i < n && cyc < n * 4 + 50) begin
      wr_valid = ($urandom_range(99) >= stall_pct);
      wr_data = DW'($urandom);
      if (wr_valid && wq.size() > 0) wr_data = wq.pop_front();
      #1;
      chk("wr_ready", wr_ready, 1);
      chk("mem_load", mem_load, wr_valid);
      if (wr_valid) begin
        a = base + AW'(i);
        chk("wr_addr", mem_address, a);
        chk("wr_mem_in", mem_in, wr_data);
        mem_ref[a] = wr_data;
        sum += wr_data;
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    wq.delete();
    chk("wr_words", i, n);
    #1;
    chk("wr_done_pulse", done, 1);
    chk("wr_busy_done", busy, 1);
    chk("wr_ready_done", wr_ready, 0);
    chk("load_done", mem_load, 0);
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
    chk("wr_checksum", checksum, sum);
`endif
    @(negedge clk);
    #1;
    chk("wr_done_len", done, 0);
    chk("wr_idle_ready", cmd_ready, 1);
    chk("wr_idle_busy", busy, 0);
    chk("wr_count", n_writes - wb, n);
    chk("wr_done_cnt", n_done - db, 1);
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
    chk("wr_checksum_hold", checksum, sum);
`endif
  endtask

  task automatic do_read(input logic [AW-1:0] base,
                         input logic [AW:0] cnt,
                         input int hold_pct,
                         input int long_at);
    int n, cyc, h, wb, db;
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
    logic [DW-1:0] sum;
    n = sat(int'(cnt));
    wb = n_writes;
    db = n_done;
    sum = '0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_base = base;
    cmd_count = cnt;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (rd_valid !== 1'b1 && cyc < 8) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      a = base + AW'(i);
      exp = mem_ref[a];
      chk("rd_latency", cyc, 2);
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, exp);
      chk("rd_wr_ready", wr_ready, 0);
      if (i == long_at) h = 5;
      else if ($urandom_range(99) < hold_pct) h = $urandom_range(3, 1);
      else h = 0;
      repeat (h) begin
        @(negedge clk);
        #1;
        chk("rd_hold_valid", rd_valid, 1);
        chk("rd_hold_data", rd_data, exp);
        chk("rd_hold_addr", mem_address, a);
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      #1;
      chk("rd_valid_low", rd_valid, 0);
      sum += exp;
    end
    chk("rd_done_pulse", done, 1);
    chk("rd_load", mem_load, 0);
`ifdef MEM_PORT_MASTER_CHECKSUM_EN
    chk("rd_checksum", checksum, sum);
`endif
    @(negedge clk);
    #1;
    chk("rd_done_len", done, 0);
    chk("rd_idle_ready", cmd_ready, 1);
    chk("rd_no_writes", n_writes - wb, 0);
    chk("rd_done_cnt", n_done - db, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_base = '0;
    cmd_count = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_ref[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_load", mem_load, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;

    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_write(14'h0010, 15'd4, 0);

    do_write(AW'($urandom), 15'd0, 0);
    do_read(AW'($urandom), 15'd0, 0, -1);

    do_write(AW'($urandom), 15'h7FFF, 0);

    do_write(14'h3FFE, 15'd4, 20);
    do_read(14'h3FFE, 15'd4, 0, -1);

    do_read(14'h1000, 15'd3, 0, 1);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(1) == 1)
        do_write(AW'($urandom), 15'($urandom_range(12, 1)), 30);
      else
        do_read(AW'($urandom), 15'($urandom_range(12, 1)), 30, -1);
    end

    rb = 14'h2345;
    w0 = n_writes;
    d0 = n_done;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_base = rb;
    cmd_count = 15'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data = DW'($urandom);
      if (i == 2) rst_n = 1'b0;
      #1;
      if (i < 2) begin
        chk("abort_load", mem_load, 1);
        mem_ref[rb + AW'(i)] = wr_data;
      end else begin
        chk("abort_load_rst", mem_load, 0);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_addr", mem_address, 0);
    chk("abort_mem_in", mem_in, 0);
    chk("abort_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_done2", done, 0);
    chk("abort_writes", n_writes - w0, 2);
    chk("abort_done_cnt", n_done - d0, 0);
    do_read(rb, 15'd8, 0, -1);

`ifdef MEM_PORT_MASTER_CHECKSUM_EN
    wq = '{16'hFFFF, 16'h0002};
    do_write(14'h0200, 15'd2, 0);
    chk("checksum_wrap", checksum, 16'h0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_master.md
MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, meaning the memory word-address width (16384 words).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the memory word width.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning the reset, synchronous and active-low.
REQ-005 The block SHALL have port cmd_valid  input  1  meaning a command is offered.
REQ-006 The block SHALL have port cmd_ready  output  1  meaning a command can be accepted.
REQ-007 The block SHALL have port cmd_write  input  1  meaning 1 = stream-to-memory, 0 = memory-to-stream.
REQ-008 The block SHALL have port cmd_base  input  ADDR_W  meaning the first word address.
REQ-009 The block SHALL have port cmd_count  input  ADDR_W+1  meaning the word count, 0..16384.
REQ-010 The block SHALL have ports wr_valid input 1, wr_ready output 1 and wr_data input DATA_W, meaning the write-data stream.
REQ-011 The block SHALL have ports rd_valid output 1, rd_ready input 1 and rd_data output DATA_W, meaning the read-data stream.
REQ-012 The block SHALL have ports mem_address output ADDR_W, mem_in output DATA_W and mem_load output 1, meaning it drives the RAM port.
REQ-013 The block SHALL have port mem_out  input  DATA_W  meaning the RAM read data, valid one cycle after its address is presented.
REQ-014 The block SHALL have ports busy output 1 and done output 1, meaning a command is in progress and a one-cycle completion pulse respectively.

Function
REQ-015 The FSM SHALL have the states IDLE, WR, RD_REQ, RD_WAIT, RD_HOLD and DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a handshake (cmd_valid && cmd_ready) SHALL latch base and count, clear the index and move to WR (cmd_write=1) or RD_REQ (cmd_write=0).
REQ-017 A command with cmd_count=0 SHALL go straight to DONE with no memory access; values above 16384 SHALL saturate to 16384.
REQ-018 mem_address SHALL equal (base + index) mod 2^ADDR_W, so a transfer wraps from 16383 to 0.
REQ-019 In WR, wr_ready SHALL be 1 and mem_load SHALL equal wr_valid, combinationally, with mem_in = wr_data; each handshake SHALL increment the index.
REQ-020 After the final write handshake the FSM SHALL enter DONE, giving one word per cycle with zero added latency.
REQ-021 RD_REQ SHALL present the address for one cycle; RD_WAIT SHALL capture mem_out into rd_data; RD_HOLD SHALL assert rd_valid with rd_data stable until rd_ready.
REQ-022 On the RD_HOLD handshake the FSM SHALL increment the index and go to RD_REQ, or to DONE after the last word, giving at most 1 word per 3 cycles.
REQ-023 mem_load SHALL be 0 in every state other than WR and in any cycle where rst_n=0.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Outside WR, wr_ready SHALL be 0; outside RD_HOLD, rd_valid SHALL be 0.

Reset
REQ-027 When rst_n=0 at a rising edge, the FSM SHALL enter IDLE and index, rd_data, mem_address and mem_in SHALL become 0.
REQ-028 After reset, cmd_ready SHALL be 1 and busy, done, rd_valid, wr_ready and mem_load SHALL be 0.
REQ-029 A reset mid-transfer SHALL abort the transfer with no done pulse and no further memory write.

Configuration
REQ-030 With macro MEM_PORT_MASTER_CHECKSUM_EN defined, the block SHALL add output checksum (DATA_W), cleared on command acceptance and accumulating (mod 2^16) each word written or delivered, stable from the done pulse until the next command.
REQ-031 Without MEM_PORT_MASTER_CHECKSUM_EN, the checksum port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-032 Write base=0x0010 count=4 data 0x1111..0x4444 with wr_valid held high -> mem_load high for 4 consecutive cycles at addresses 0x0010..0x0013, then done for 1 cycle.
REQ-033 Read base=0x3FFE count=4 after preload -> rd_data from addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 in order (wrap).
REQ-034 Read with rd_ready low for 5 cycles in RD_HOLD -> rd_valid and rd_data held stable, no index advance.
REQ-035 cmd_count=0 -> done 1 cycle after acceptance, mem_load never asserted.
REQ-036 rst_n low during the 3rd of 8 writes -> IDLE next cycle, no done, exactly 2 words written.
REQ-037 With MEM_PORT_MASTER_CHECKSUM_EN, write 0xFFFF,0x0002 -> checksum=0x0001 at done.
